muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Execute-stage multi-cycle M-extension engine that consumes alu_ctrl codes.
//   Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with RV32M semantics and stalls the pipe via busy_o.
//   Single-cycle ALU ops stay in the ALU; this block accepts only the eight M-ext codes.
// PARAMETERS
//   XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//   clk         in   1         clock; the block uses one clock
//   rst_n       in   1         asynchronous, active-low reset
//   start_i     in   1         request valid; sampled only when ready_o=1
//   alu_ctrl_i  in   ALU_OP    operation code (ALU_MUL..ALU_REMU)
//   op_a_i      in   XLEN      rs1 value (dividend / multiplicand)
//   op_b_i      in   XLEN      rs2 value (divisor / multiplier)
//   flush_i     in   1         abort in-flight op (branch mispredict / trap)
//   ready_o     out  1         high only in MD_IDLE
//   busy_o      out  1         high in MD_CALC and MD_DONE; drives the hazard unit's stall
//   done_o      out  1         one-cycle pulse; result_o is valid in that cycle
//   result_o    out  XLEN      result; holds until the next acceptance
// BEHAVIOUR
//   - Reset (async): state=MD_IDLE, ready_o=1, busy_o=0, done_o=0, result_o=0, count=0.
//   - Accept at edge E0 when start_i & ready_o & op is M-ext. Latch op, operands and sign flags.
//     Non-M-ext codes are ignored and ready_o stays 1.
//   - FSM: MD_IDLE -accept-> MD_CALC, or MD_DONE for special/fast cases.
//     MD_CALC -count==XLEN-1-> MD_DONE. MD_DONE -> MD_IDLE unconditionally.
//   - Iterative path: operands converted to magnitudes; one bit per cycle.
//     Divide is restoring shift-subtract; multiply is shift-add into a 2*XLEN accumulator.
//     Sign fix-up is applied on the transition into MD_DONE.
//     done_o is high in the cycle after edge E0+XLEN+1.
//   - Signedness: MUL low word; MULH s*s high; MULHSU s(a)*u(b) high; MULHU u*u high.
//     DIV/REM signed, DIVU/REMU unsigned. REM takes the sign of the dividend.
//   - Special cases resolve directly to MD_DONE; done_o is high in the cycle after edge E0+1.
//     b==0: DIV/DIVU -> all ones; REM/REMU -> op_a.
//     DIV with a=-2^(XLEN-1), b=-1 -> -2^(XLEN-1); REM -> 0.
//   - start_i while busy_o=1 is ignored; no queuing.
//   - flush_i has priority over everything: next edge -> MD_IDLE, done_o=0, result_o unchanged.
//     flush_i in the same cycle as an accepting start_i cancels the accept.
//   - Reset asserted mid-operation aborts immediately; no done_o pulse.
// CONFIGURATION
//   MULDIV_FAST_MUL_EN defined: MUL* use a single-cycle XLEN x XLEN multiplier.
//     Path IDLE->DONE, done_o in the cycle after edge E0+1.
//   Undefined: MUL* share the iterative engine (XLEN+1 latency); no hardware multiplier is inferred.
//   Divide latency and special-case handling are identical in both builds.
// STRUCTURE
//   all_pkgs: XLEN, ALU_OP, ALU_MUL..ALU_REMU codes (existing).
//   all_pkgs: add typedef enum muldiv_state_e {MD_IDLE, MD_CALC, MD_DONE}.
//   all_pkgs: add function is_muldiv(alu_ctrl) returning 1 for the eight M-ext codes.
//   Sub-module muldiv_iter_core: shift-add/shift-subtract datapath plus the iteration counter.
//   Top level keeps the FSM, special-case detection, sign fix-up and the handshake.
// TESTING
//   1. DIVU 100/7 -> result 14, done_o at E0+33; REMU 100/7 -> 2; ready_o low throughout.
//   2. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at E0+1; REM -> 0. DIV -7/2 -> -3; REM -> -1.
//   3. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; both at E0+1.
//   4. a=b=0xFFFFFFFF: MUL -> 1, MULH -> 0, MULHU -> 0xFFFFFFFE, MULHSU -> 0xFFFFFFFF.
//      Latency E0+1 with MULDIV_FAST_MUL_EN, E0+33 without.
//   5. DIVU started, flush_i at cycle 10 -> no done_o, ready_o=1 next cycle, result_o unchanged.
//      rst_n low mid-op -> all outputs return to reset values immediately.
//   6. start_i with ALU_ADD -> ignored. start_i while busy -> ignored.
//      Back-to-back DIVU accepted the cycle after done_o.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide engine: XLEN, ALU op codes, FSM states.
// Build option MULDIV_FAST_MUL_EN (see muldiv_unit.sv) does not affect this package.
package muldiv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [4:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_MUL,
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU,
      ALU_DIV,
      ALU_DIVU,
      ALU_REM,
      ALU_REMU
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_CALC,
      MD_DONE
   } muldiv_state_e;

   function automatic logic is_muldiv(input alu_op_e op);
      return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide, plus the iteration counter.
module muldiv_iter_core
   import muldiv_pkg::*;
#(
   parameter int W = XLEN
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         step_i,
   input  logic         isDiv_i,
   input  logic [W-1:0] magA_i,
   input  logic [W-1:0] magB_i,
   output logic [W-1:0] hiNext_o,
   output logic [W-1:0] loNext_o,
   output logic         last_o
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  hi_q, lo_q, opnd_q;
   logic          isDiv_q;
   logic [CW-1:0] count_q;
   logic [W-1:0]  hi_d, lo_d;
   logic [W:0]    shifted, trial, sum;

   // hi/lo hold product {hi,lo} for multiply, or {remainder,quotient} for divide
   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      shifted = {hi_q, lo_q[W-1]};
      trial   = shifted - {1'b0, opnd_q};
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      if (isDiv_q) begin
         if (!trial[W]) begin
            hi_d = trial[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b1};
         end else begin
            hi_d = shifted[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b0};
         end
      end else begin
         hi_d = sum[W:1];
         lo_d = {sum[0], lo_q[W-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q    <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         isDiv_q <= 1'b0;
         count_q <= '0;
      end else if (load_i) begin
         hi_q    <= '0;
         lo_q    <= isDiv_i ? magA_i : magB_i;
         opnd_q  <= isDiv_i ? magB_i : magA_i;
         isDiv_q <= isDiv_i;
         count_q <= '0;
      end else if (step_i) begin
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         count_q <= count_q + CW'(1);
      end
   end

   assign hiNext_o = hi_d;
   assign loNext_o = lo_d;
   assign last_o   = (count_q == CW'(W - 1));

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide engine with handshake, special cases and sign fix-up.
// Define MULDIV_FAST_MUL_EN to resolve MUL* in one cycle with a hardware multiplier.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  alu_op_e         alu_ctrl_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   output logic            ready_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   muldiv_state_e   state_q;
   alu_op_e         op_q;
   logic            negA_q, negB_q, done_q;
   logic [XLEN-1:0] res_q, result_q;

   logic            accept, isDivOp, isRemOp, signedA, signedB, negA, negB;
   logic            divZero, divOvf, fastPath, goDone, coreLoad, coreStep, coreLast;
   logic [XLEN-1:0] magA, magB, specRes, fastRes, hiNext, loNext, fixedRes;
   logic [2*XLEN-1:0] prodFix;

   assign accept  = start_i & (state_q == MD_IDLE) & is_muldiv(alu_ctrl_i) & ~flush_i;
   assign isDivOp = alu_ctrl_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   assign isRemOp = alu_ctrl_i inside {ALU_REM, ALU_REMU};
   assign signedA = alu_ctrl_i inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
   assign signedB = alu_ctrl_i inside {ALU_MULH, ALU_DIV, ALU_REM};
   assign negA    = signedA & op_a_i[XLEN-1];
   assign negB    = signedB & op_b_i[XLEN-1];
   assign magA    = negA ? -op_a_i : op_a_i;
   assign magB    = negB ? -op_b_i : op_b_i;

   // Cases that bypass the iterative engine entirely
   assign divZero = isDivOp & (op_b_i == '0);
   assign divOvf  = (alu_ctrl_i inside {ALU_DIV, ALU_REM}) &
                    (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == '1);
   assign specRes = divZero ? (isRemOp ? op_a_i : '1) : (isRemOp ? '0 : op_a_i);

`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*XLEN+1:0] fullProd;
   logic                     unusedProdTop;
   assign fullProd      = $signed({signedA & op_a_i[XLEN-1], op_a_i}) *
                          $signed({signedB & op_b_i[XLEN-1], op_b_i});
   assign unusedProdTop = ^fullProd[2*XLEN+1:2*XLEN];
   assign fastPath      = ~isDivOp;
   assign fastRes       = (alu_ctrl_i == ALU_MUL) ? fullProd[XLEN-1:0]
                                                  : fullProd[2*XLEN-1:XLEN];
`else
   assign fastPath = 1'b0;
   assign fastRes  = '0;
`endif

   assign goDone   = divZero | divOvf | fastPath;
   assign coreLoad = accept & ~goDone;
   assign coreStep = (state_q == MD_CALC) & ~flush_i;

   muldiv_iter_core #(.W(XLEN)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (coreLoad),
      .step_i   (coreStep),
      .isDiv_i  (isDivOp),
      .magA_i   (magA),
      .magB_i   (magB),
      .hiNext_o (hiNext),
      .loNext_o (loNext),
      .last_o   (coreLast)
   );

   // Sign fix-up works on the value the core produces on its final step
   assign prodFix = (negA_q ^ negB_q) ? -{hiNext, loNext} : {hiNext, loNext};

   always_comb begin
      fixedRes = '0;
      case (op_q)
         ALU_MUL:                          fixedRes = prodFix[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU:  fixedRes = prodFix[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:                fixedRes = (negA_q ^ negB_q) ? -loNext : loNext;
         ALU_REM, ALU_REMU:                fixedRes = negA_q ? -hiNext : hiNext;
         default:                          fixedRes = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= MD_IDLE;
         op_q     <= ALU_ADD;
         negA_q   <= 1'b0;
         negB_q   <= 1'b0;
         res_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (flush_i) begin
            state_q <= MD_IDLE;
         end else begin
            case (state_q)
               MD_IDLE: begin
                  if (accept) begin
                     op_q   <= alu_ctrl_i;
                     negA_q <= negA;
                     negB_q <= negB;
                     if (goDone) begin
                        res_q   <= (divZero | divOvf) ? specRes : fastRes;
                        state_q <= MD_DONE;
                     end else begin
                        state_q <= MD_CALC;
                     end
                  end
               end
               MD_CALC: begin
                  if (coreLast) begin
                     res_q   <= fixedRes;
                     state_q <= MD_DONE;
                  end
               end
               MD_DONE: begin
                  result_q <= res_q;
                  done_q   <= 1'b1;
                  state_q  <= MD_IDLE;
               end
               default: state_q <= MD_IDLE;
            endcase
         end
      end
   end

   assign ready_o  = (state_q == MD_IDLE);
   assign busy_o   = (state_q != MD_IDLE);
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected result and done cycle,
// a negedge monitor pops and compares on every done_o pulse.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   alu_op_e     alu_ctrl_i = ALU_ADD;
   logic [31:0] op_a_i = '0;
   logic [31:0] op_b_i = '0;
   logic        ready_o, busy_o, done_o;
   logic [31:0] result_o;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MulLat = 1;
`else
   localparam int MulLat = 33;
`endif
   localparam int DivLat  = 33;
   localparam int SpecLat = 1;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          assertCount = 0;
   int          failCount = 0;
   int          cycleCnt = 0;
   logic [31:0] lastResult = '0;

   muldiv_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .alu_ctrl_i (alu_ctrl_i),
      .op_a_i     (op_a_i),
      .op_b_i     (op_b_i),
      .flush_i    (flush_i),
      .ready_o    (ready_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done_o pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done_o) begin
         if (sb.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected_done: done_o=1 with nothing outstanding, result 0x%08h",
                     result_o);
         end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_result"}, result_o, e.res);
            checkOutput({e.name, "_done_cycle"}, cycleCnt, e.cyc);
            lastResult = e.res;
         end
      end
   end

   // Called #1 after a posedge; waits for ready_o, drives one start cycle
   task automatic applyStimulus(input string name, input alu_op_e op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expRes,
                                input int lat, input bit expectDone);
      exp_t e;
      int   guard = 0;
      while (!ready_o && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!ready_o) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL %s_ready_timeout: ready_o=%0b, required 1", name, ready_o);
      end
      start_i    = 1'b1;
      alu_ctrl_i = op;
      op_a_i     = a;
      op_b_i     = b;
      if (expectDone) begin
         e.res  = expRes;
         e.cyc  = cycleCnt + 1 + lat;
         e.name = name;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic waitIdle(input int maxCycles);
      int g = 0;
      while (sb.size() != 0 && g < maxCycles) begin
         @(posedge clk); #1;
         g++;
      end
      if (sb.size() != 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL done_timeout: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bit seenReady;

      #12;
      checkOutput("reset_ready", {31'b0, ready_o}, 32'd1);
      checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
      checkOutput("reset_done", {31'b0, done_o}, 32'd0);
      checkOutput("reset_result", result_o, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idleCycles(2);

      // Unsigned divide, engine stays busy for the whole iteration
      applyStimulus("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, DivLat, 1'b1);
      seenReady = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (ready_o !== 1'b0) seenReady = 1'b1;
         @(posedge clk); #1;
      end
      checkOutput("divu_ready_low", {31'b0, seenReady}, 32'd0);
      waitIdle(100);
      applyStimulus("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, DivLat, 1'b1);
      waitIdle(100);

      // Signed overflow and signed rounding toward zero
      applyStimulus("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpecLat, 1'b1);
      applyStimulus("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SpecLat, 1'b1);
      applyStimulus("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DivLat, 1'b1);
      applyStimulus("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DivLat, 1'b1);
      applyStimulus("div_100_m7", ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, DivLat, 1'b1);
      waitIdle(200);

      // Divide by zero
      applyStimulus("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SpecLat, 1'b1);
      applyStimulus("remu_5_0", ALU_REMU, 32'd5, 32'd0, 32'd5, SpecLat, 1'b1);
      applyStimulus("div_m3_0", ALU_DIV, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFF, SpecLat, 1'b1);
      waitIdle(50);

      // Multiply signedness variants
      applyStimulus("mul_ff", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MulLat, 1'b1);
      applyStimulus("mulh_ff", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MulLat, 1'b1);
      applyStimulus("mulhu_ff", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat, 1'b1);
      applyStimulus("mulhsu_ff", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat, 1'b1);
      applyStimulus("mul_1234", ALU_MUL, 32'd1234, 32'd5678, 32'd7006652, MulLat, 1'b1);
      applyStimulus("mulh_neg", ALU_MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, MulLat, 1'b1);
      waitIdle(300);

      // Flush cancels an in-flight divide without a done pulse
      applyStimulus("divu_flush", ALU_DIVU, 32'd1000, 32'd3, 32'd0, DivLat, 1'b0);
      idleCycles(9);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      checkOutput("flush_ready", {31'b0, ready_o}, 32'd1);
      checkOutput("flush_busy", {31'b0, busy_o}, 32'd0);
      checkOutput("flush_result_held", result_o, lastResult);
      idleCycles(40);

      // Asynchronous reset mid-operation
      applyStimulus("divu_reset", ALU_DIVU, 32'd77, 32'd5, 32'd0, DivLat, 1'b0);
      idleCycles(5);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_ready", {31'b0, ready_o}, 32'd1);
      checkOutput("midreset_busy", {31'b0, busy_o}, 32'd0);
      checkOutput("midreset_done", {31'b0, done_o}, 32'd0);
      checkOutput("midreset_result", result_o, 32'd0);
      lastResult = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idleCycles(40);

      // Non-M-ext op is ignored
      start_i    = 1'b1;
      alu_ctrl_i = ALU_ADD;
      op_a_i     = 32'd3;
      op_b_i     = 32'd4;
      @(posedge clk); #1;
      start_i = 1'b0;
      checkOutput("add_ignored_ready", {31'b0, ready_o}, 32'd1);
      checkOutput("add_ignored_busy", {31'b0, busy_o}, 32'd0);
      idleCycles(40);

      // start while busy is dropped; the original op still completes
      applyStimulus("divu_busy", ALU_DIVU, 32'd100, 32'd7, 32'd14, DivLat, 1'b1);
      start_i    = 1'b1;
      alu_ctrl_i = ALU_DIVU;
      op_a_i     = 32'd9;
      op_b_i     = 32'd3;
      @(posedge clk); #1;
      start_i = 1'b0;
      checkOutput("busy_start_ignored", {31'b0, busy_o}, 32'd1);
      waitIdle(100);
      idleCycles(40);

      // Back-to-back divides accepted as soon as ready_o returns
      applyStimulus("b2b_first", ALU_DIVU, 32'd1000, 32'd10, 32'd100, DivLat, 1'b1);
      applyStimulus("b2b_second", ALU_REMU, 32'd1000, 32'd7, 32'd6, DivLat, 1'b1);
      waitIdle(200);
      idleCycles(5);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
